traffic_request_latch: RTL
==========================

# traffic_request_latch

Conditions the four Nexys4DDR push buttons into clean, latched vehicle-detector requests for the traffic-light controller. Each button passes through a 2-flop synchronizer and a per-button debounce state machine. Left/right presses latch an east-west request; up/down presses latch a north-south request. Each request holds until the traffic-light state machine pulses the matching clear, which it does when that road's green begins. The block sits directly upstream of the traffic-light state machine and replaces its free-running shift-register cleaners.

## Interface
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles needed before a debounced level changes (10 ms at 100 MHz). Legal range ≥ 2.
- CNT_W, default $clog2(DEBOUNCE_CYCLES+1): width of the debounce counter.

Ports:
- CLK100MHZ  in  1  sole clock; every flop uses the rising edge.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- BTNU, BTND, BTNL, BTNR  in  1 each  raw, asynchronous, bouncing button inputs, active high.
- clear_east_west  in  1  single-cycle pulse from the traffic FSM: east-west request served.
- clear_north_south  in  1  single-cycle pulse from the traffic FSM: north-south request served.
- request_east_west  out  1  latched pending east-west request.
- request_north_south  out  1  latched pending north-south request.
- press_count_ew  out  4  east-west presses since last clear, saturating at 15.
- press_count_ns  out  4  north-south presses since last clear, saturating at 15.
- btn_level  out  4  debounced levels, ordered {U,D,L,R}.

## Operation
- **Synchronizer:** each button goes through 2 flops (s1, s2). Reset value is 0.
- **Debounce FSM, one per button:** states IDLE_LOW, CHECK_HIGH, HELD_HIGH, CHECK_LOW. Counter cnt is CNT_W bits.
  - IDLE_LOW: if s2=1, go to CHECK_HIGH with cnt=1.
  - CHECK_HIGH: if s2=0, return to IDLE_LOW with cnt=0 (bounce). Else if cnt==DEBOUNCE_CYCLES-1, go to HELD_HIGH, set level=1, and pulse press=1 for one cycle. Else cnt+1.
  - HELD_HIGH: if s2=0, go to CHECK_LOW with cnt=1.
  - CHECK_LOW: if s2=1, return to HELD_HIGH with cnt=0. Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE_LOW and set level=0 (no pulse). Else cnt+1.
  - Illegal state encodings recover to IDLE_LOW with cnt=0.
- **Request pulses:**
  - press_ew = pressL | pressR.
  - press_ns = pressU | pressD.
  - Simultaneous L and R press pulses count as one press.
- **Request latch, per road:**
  - A press pulse sets the request; a clear pulse resets it.
  - If press and clear arrive in the same cycle, **press wins**: the request stays 1 and the count becomes 1.
- **Press count, per road:**
  - Clear alone sets the count to 0.
  - A press alone increments the count, saturating at 15.
  - Clear with no pending request is harmless: the request and count stay 0.
- **Reset:** all outputs are 0, all FSMs are in IDLE_LOW, all counters and synchronizers are 0. Asserting reset mid-debounce or with a pending request discards everything. After release, a button already held high must debounce afresh and produces exactly one press.

## Timing
- Raw input rising at edge k reaches s2 at edge k+2.
- With the input stable high, level and press become 1 at edge k+2+DEBOUNCE_CYCLES-1.
- The request and count update on the following edge. Total press-to-request latency is DEBOUNCE_CYCLES+2 cycles.
- Clear-to-request-low latency is 1 cycle (registered).
- Any glitch shorter than DEBOUNCE_CYCLES cycles produces no level change and no press.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
Use DEBOUNCE_CYCLES=4 on the bench.

1. **Reset:** assert CPU_RESETN=0 mid-run → all outputs 0 asynchronously, before the next edge.
2. **Clean press:** BTNL high at edge 10, held → btn_level[1]=1 at edge 15, request_east_west=1 and press_count_ew=1 at edge 16. Then clear_east_west pulse → request 0 and count 0 the next edge.
3. **Bounce:** BTNR toggles 1,0,1,0 every 2 cycles, then held high → no request during the bounce; exactly one press once held for 4 cycles. A 3-cycle release gap while held → no second press.
4. **Collision and simultaneity:**
   - clear_north_south in the same cycle as the BTNU press pulse → request_north_south stays 1 and press_count_ns=1.
   - BTNU and BTND rising together → count increments by 1, not 2.
5. **Saturation and independence:** 17 separate BTND presses with no clear → press_count_ns stops at 15. East-west outputs stay unaffected throughout.
6. **Reset mid-operation:**
   - Reset during CHECK_HIGH → no press after release until the button is stable for 4 cycles.
   - Button held through reset release → exactly one request.

Source files
------------

// File: rtl/traffic_request_latch.sv
`default_nettype none
//==============================================================================
// Module   : traffic_request_latch
// Purpose  : Turns the four Nexys4DDR push buttons into clean, latched
//            vehicle-detector requests for the traffic-light controller.
//            Each button is synchronized (2 flops) and debounced by its own
//            state machine. L/R presses latch an east-west request and U/D
//            presses latch a north-south request. A request holds until the
//            traffic FSM pulses the matching clear. A per-road press counter
//            saturates at 15.
// Ports    : CLK100MHZ           - sole clock, rising edge
//            CPU_RESETN          - asynchronous active-low reset
//            BTNU/BTND/BTNL/BTNR - raw bouncing buttons, active high
//            clear_east_west     - 1-cycle pulse, east-west request served
//            clear_north_south   - 1-cycle pulse, north-south request served
//            request_east_west   - latched pending east-west request
//            request_north_south - latched pending north-south request
//            press_count_ew      - east-west presses since clear (sat. 15)
//            press_count_ns      - north-south presses since clear (sat. 15)
//            btn_level           - debounced levels {U,D,L,R}
// Revision : 1.0 - initial release
//==============================================================================
module traffic_request_latch #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic       CLK100MHZ,
   input  logic       CPU_RESETN,
   input  logic       BTNU,
   input  logic       BTND,
   input  logic       BTNL,
   input  logic       BTNR,
   input  logic       clear_east_west,
   input  logic       clear_north_south,
   output logic       request_east_west,
   output logic       request_north_south,
   output logic [3:0] press_count_ew,
   output logic [3:0] press_count_ns,
   output logic [3:0] btn_level
);

   typedef enum logic [1:0] {
      IDLE_LOW   = 2'd0,
      CHECK_HIGH = 2'd1,
      HELD_HIGH  = 2'd2,
      CHECK_LOW  = 2'd3
   } debounce_state_t;

   // The counter already holds 1 on entry to a CHECK state, so reaching
   // DEBOUNCE_CYCLES-1 while still stable means DEBOUNCE_CYCLES samples.
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]       c_cnt_max  = 4'd15;

   logic [3:0] w_btn_raw;
   logic [3:0] r_s1;
   logic [3:0] r_s2;
   logic [3:0] w_level;
   logic [3:0] w_press;
   logic       w_press_ew;
   logic       w_press_ns;

   logic       r_req_ew;
   logic       r_req_ns;
   logic [3:0] r_cnt_ew;
   logic [3:0] r_cnt_ns;

   // Bit order matches btn_level: {U,D,L,R}
   assign w_btn_raw = {BTNU, BTND, BTNL, BTNR};

   //---------------------------------------------------------------------------
   // Two-flop synchronizer for all four buttons
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_s1 <= 4'b0000;
         r_s2 <= 4'b0000;
      end else begin
         r_s1 <= w_btn_raw;
         r_s2 <= r_s1;
      end
   end

   //---------------------------------------------------------------------------
   // Per-button debounce state machine
   //---------------------------------------------------------------------------
   for (genvar g = 0; g < 4; g++) begin : g_btn
      debounce_state_t  r_state;
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;
      logic             r_press;
      logic             w_s2;

      assign w_s2 = r_s2[g];

      always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
         if (!CPU_RESETN) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
         end else begin
            // press is a single-cycle strobe unless re-asserted below
            r_press <= 1'b0;
            case (r_state)
               IDLE_LOW: begin
                  if (w_s2) begin
                     r_state <= CHECK_HIGH;
                     r_cnt   <= c_cnt_one;
                  end
               end
               CHECK_HIGH: begin
                  if (!w_s2) begin
                     r_state <= IDLE_LOW;
                     r_cnt   <= '0;
                  end else if (r_cnt == c_cnt_last) begin
                     r_state <= HELD_HIGH;
                     r_cnt   <= '0;
                     r_level <= 1'b1;
                     r_press <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + c_cnt_one;
                  end
               end
               HELD_HIGH: begin
                  if (!w_s2) begin
                     r_state <= CHECK_LOW;
                     r_cnt   <= c_cnt_one;
                  end
               end
               CHECK_LOW: begin
                  if (w_s2) begin
                     r_state <= HELD_HIGH;
                     r_cnt   <= '0;
                  end else if (r_cnt == c_cnt_last) begin
                     // release is silent: only rising edges count as presses
                     r_state <= IDLE_LOW;
                     r_cnt   <= '0;
                     r_level <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + c_cnt_one;
                  end
               end
               default: begin
                  r_state <= IDLE_LOW;
                  r_cnt   <= '0;
                  r_level <= 1'b0;
               end
            endcase
         end
      end

      assign w_level[g] = r_level;
      assign w_press[g] = r_press;
   end

   // Simultaneous presses on the same road merge into a single press
   assign w_press_ew = w_press[1] | w_press[0];
   assign w_press_ns = w_press[3] | w_press[2];

   //---------------------------------------------------------------------------
   // Request latches and saturating press counters. A press arriving in the
   // same cycle as a clear wins: the new press is the only one outstanding.
   //---------------------------------------------------------------------------
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_req_ew <= 1'b0;
         r_cnt_ew <= 4'd0;
      end else if (w_press_ew) begin
         r_req_ew <= 1'b1;
         if (clear_east_west) begin
            r_cnt_ew <= 4'd1;
         end else if (r_cnt_ew != c_cnt_max) begin
            r_cnt_ew <= r_cnt_ew + 4'd1;
         end
      end else if (clear_east_west) begin
         r_req_ew <= 1'b0;
         r_cnt_ew <= 4'd0;
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_req_ns <= 1'b0;
         r_cnt_ns <= 4'd0;
      end else if (w_press_ns) begin
         r_req_ns <= 1'b1;
         if (clear_north_south) begin
            r_cnt_ns <= 4'd1;
         end else if (r_cnt_ns != c_cnt_max) begin
            r_cnt_ns <= r_cnt_ns + 4'd1;
         end
      end else if (clear_north_south) begin
         r_req_ns <= 1'b0;
         r_cnt_ns <= 4'd0;
      end
   end

   assign request_east_west   = r_req_ew;
   assign request_north_south = r_req_ns;
   assign press_count_ew      = r_cnt_ew;
   assign press_count_ns      = r_cnt_ns;
   assign btn_level           = w_level;

endmodule
`default_nettype wire
